// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Package : mem_pkg
//  Purpose : Shared types, request/error codes and helpers for the
//            proc_mem_responder slice.
//  Revision: 1.0  initial release
// ============================================================================
package mem_pkg;

   typedef enum logic [0:0] {
      MEM_RUN  = 1'b0,
      MEM_LOAD = 1'b1
   } mem_state_e;

   localparam logic MEM_READ  = 1'b0;
   localparam logic MEM_WRITE = 1'b1;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_MISALIGN = 2'd1;
   localparam logic [1:0] ERR_RANGE    = 2'd2;
   localparam logic [1:0] ERR_BUSY     = 2'd3;

   // Classifies a core byte address. The window base is aligned to the
   // window size, so "in range" reduces to the bits above the window
   // matching the base. Misalignment is reported ahead of range.
   function automatic logic [1:0] addr_err(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int          aw);
      logic [31:0] hi_mask;
      hi_mask = ~((32'd4 << aw) - 32'd1);
      if (addr[1:0] != 2'b00)
         return ERR_MISALIGN;
      else if ((addr & hi_mask) != base)
         return ERR_RANGE;
      else
         return ERR_NONE;
   endfunction

   // Saturating increment: holds at all-ones.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_dp_ram.sv
`default_nettype none
// ============================================================================
//  Module  : mem_dp_ram
//  Purpose : DEPTH x 32 storage, two combinational read ports, one
//            synchronous write port. Contents are never reset.
//  Ports   : clk               clock
//            rd0_addr/rd0_data read port 0 (word index / data)
//            rd1_addr/rd1_data read port 1 (word index / data)
//            we/waddr/wdata    write enable, word index, data
//  Revision: 1.0  initial release
// ============================================================================
module mem_dp_ram #(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic [AW-1:0] rd0_addr,
   output logic [31:0]   rd0_data,
   input  logic [AW-1:0] rd1_addr,
   output logic [31:0]   rd1_data,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata
);

   localparam int DEPTH = 2 ** AW;

   logic [31:0] mem [0:DEPTH-1];

   // Reads see the array before this cycle's write commits, which gives
   // read-old-data behaviour for a same-cycle read/write of one word.
   assign rd0_data = mem[rd0_addr];
   assign rd1_data = mem[rd1_addr];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

endmodule : mem_dp_ram
`default_nettype wire

// File: rtl/proc_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module  : proc_mem_responder
//  Purpose : Memory-side responder for a pipelined TinyRV1 core. Serves
//            same-cycle imem fetches and dmem loads/stores, accepts a
//            val/rdy preload stream, keeps a sticky error and saturating
//            access counters.
//  Ports   : clk, rst (async, active-high)
//            imemreq_val/addr, imemresp_data        fetch port
//            dmemreq_val/type/addr/wdata,
//            dmemresp_rdata                         data port
//            load_start/base/len/val/data, load_rdy preload stream
//            busy                                   high while preloading
//            err, err_code, err_clr                 sticky error
//            cnt_ifetch, cnt_load, cnt_store        access counters
//  Revision: 1.0  initial release
// ============================================================================
module proc_mem_responder
   import mem_pkg::*;
#(
   parameter int          AW        = 8,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          imemreq_val,
   input  logic [31:0]   imemreq_addr,
   output logic [31:0]   imemresp_data,
   input  logic          dmemreq_val,
   input  logic          dmemreq_type,
   input  logic [31:0]   dmemreq_addr,
   input  logic [31:0]   dmemreq_wdata,
   output logic [31:0]   dmemresp_rdata,
   input  logic          load_start,
   input  logic [31:0]   load_base,
   input  logic [AW:0]   load_len,
   input  logic          load_val,
   output logic          load_rdy,
   input  logic [31:0]   load_data,
   output logic          busy,
   output logic          err,
   output logic [1:0]    err_code,
   input  logic          err_clr,
   output logic [31:0]   cnt_ifetch,
   output logic [31:0]   cnt_load,
   output logic [31:0]   cnt_store
);

   mem_state_e    state;
   logic [AW-1:0] ptr;
   logic [AW:0]   remaining;

   logic          run;
   logic [1:0]    ierr;
   logic [1:0]    derr;
   logic          i_ok;
   logic          d_ok;
   logic          d_rd_ok;
   logic          d_wr_ok;
   logic [31:0]   irdata;
   logic [31:0]   drdata;
   logic          ram_we;
   logic [AW-1:0] ram_waddr;
   logic [31:0]   ram_wdata;
   logic          new_err;
   logic [1:0]    new_code;

   // Only the word-index bits of the preload base matter: the window is
   // size-aligned, so the index equals the low address bits.
   logic          unused_ok;
   assign unused_ok = ^{load_base[31:AW+2], load_base[1:0]};

   assign run      = (state == MEM_RUN);
   assign load_rdy = ~run;
   assign busy     = ~run;

   assign ierr = addr_err(imemreq_addr, BASE_ADDR, AW);
   assign derr = addr_err(dmemreq_addr, BASE_ADDR, AW);

   assign i_ok    = run && imemreq_val && (ierr == ERR_NONE);
   assign d_ok    = run && dmemreq_val && (derr == ERR_NONE);
   assign d_rd_ok = d_ok && (dmemreq_type == MEM_READ);
   assign d_wr_ok = d_ok && (dmemreq_type == MEM_WRITE);

   assign imemresp_data  = i_ok    ? irdata : 32'd0;
   assign dmemresp_rdata = d_rd_ok ? drdata : 32'd0;

   // Single write port: the core owns it in RUN, the preload stream in LOAD.
   assign ram_we    = run ? d_wr_ok                   : load_val;
   assign ram_waddr = run ? dmemreq_addr[AW+1:2]      : ptr;
   assign ram_wdata = run ? dmemreq_wdata             : load_data;

   mem_dp_ram #(
      .AW (AW)
   ) u_ram (
      .clk      (clk),
      .rd0_addr (imemreq_addr[AW+1:2]),
      .rd0_data (irdata),
      .rd1_addr (dmemreq_addr[AW+1:2]),
      .rd1_data (drdata),
      .we       (ram_we),
      .waddr    (ram_waddr),
      .wdata    (ram_wdata)
   );

   // Error detection for this cycle; imem is reported ahead of dmem when
   // both ports are bad together.
   always_comb begin
      new_err  = 1'b0;
      new_code = ERR_NONE;
      if (!run) begin
         if (imemreq_val || dmemreq_val) begin
            new_err  = 1'b1;
            new_code = ERR_BUSY;
         end
      end else if (imemreq_val && (ierr != ERR_NONE)) begin
         new_err  = 1'b1;
         new_code = ierr;
      end else if (dmemreq_val && (derr != ERR_NONE)) begin
         new_err  = 1'b1;
         new_code = derr;
      end
   end

   // Sticky error: the first code is held; a clear in the same cycle as a
   // new error lets the new error through.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err      <= 1'b0;
         err_code <= ERR_NONE;
      end else if (new_err && (!err || err_clr)) begin
         err      <= 1'b1;
         err_code <= new_code;
      end else if (err_clr) begin
         err      <= 1'b0;
         err_code <= ERR_NONE;
      end
   end

   // RUN <-> LOAD sequencer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= MEM_RUN;
         ptr       <= '0;
         remaining <= '0;
      end else begin
         case (state)
            MEM_RUN: begin
               if (load_start && (load_len != '0)) begin
                  state     <= MEM_LOAD;
                  ptr       <= load_base[AW+1:2];
                  remaining <= load_len;
               end
            end
            MEM_LOAD: begin
               if (load_val) begin
                  ptr       <= ptr + 1'b1;
                  remaining <= remaining - 1'b1;
                  if (remaining == {{AW{1'b0}}, 1'b1})
                     state <= MEM_RUN;
               end
            end
            default: state <= MEM_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_ifetch <= 32'd0;
         cnt_load   <= 32'd0;
         cnt_store  <= 32'd0;
      end else begin
         if (i_ok)    cnt_ifetch <= sat_inc(cnt_ifetch);
         if (d_rd_ok) cnt_load   <= sat_inc(cnt_load);
         if (d_wr_ok) cnt_store  <= sat_inc(cnt_store);
      end
   end

endmodule : proc_mem_responder
`default_nettype wire

// File: tb/tb_proc_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module  : tb_proc_mem_responder
//  Purpose : Directed self-checking bench for proc_mem_responder
//            (AW = 8, BASE_ADDR = 0).
//  Revision: 1.0  initial release
// ============================================================================
module tb_proc_mem_responder;

   localparam int          AW       = 8;
   localparam logic [31:0] OLD_WORD = 32'h5555_AAAA;

   logic          clk = 1'b0;
   logic          rst;
   logic          imemreq_val;
   logic [31:0]   imemreq_addr;
   logic [31:0]   imemresp_data;
   logic          dmemreq_val;
   logic          dmemreq_type;
   logic [31:0]   dmemreq_addr;
   logic [31:0]   dmemreq_wdata;
   logic [31:0]   dmemresp_rdata;
   logic          load_start;
   logic [31:0]   load_base;
   logic [AW:0]   load_len;
   logic          load_val;
   logic          load_rdy;
   logic [31:0]   load_data;
   logic          busy;
   logic          err;
   logic [1:0]    err_code;
   logic          err_clr;
   logic [31:0]   cnt_ifetch;
   logic [31:0]   cnt_load;
   logic [31:0]   cnt_store;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   proc_mem_responder #(
      .AW        (AW),
      .BASE_ADDR (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imemreq_val    (imemreq_val),
      .imemreq_addr   (imemreq_addr),
      .imemresp_data  (imemresp_data),
      .dmemreq_val    (dmemreq_val),
      .dmemreq_type   (dmemreq_type),
      .dmemreq_addr   (dmemreq_addr),
      .dmemreq_wdata  (dmemreq_wdata),
      .dmemresp_rdata (dmemresp_rdata),
      .load_start     (load_start),
      .load_base      (load_base),
      .load_len       (load_len),
      .load_val       (load_val),
      .load_rdy       (load_rdy),
      .load_data      (load_data),
      .busy           (busy),
      .err            (err),
      .err_code       (err_code),
      .err_clr        (err_clr),
      .cnt_ifetch     (cnt_ifetch),
      .cnt_load       (cnt_load),
      .cnt_store      (cnt_store)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic start_load(input logic [31:0] base, input logic [AW:0] len);
      load_base  = base;
      load_len   = len;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      imemreq_val   = 1'b0;
      imemreq_addr  = 32'd0;
      dmemreq_val   = 1'b0;
      dmemreq_type  = 1'b0;
      dmemreq_addr  = 32'd0;
      dmemreq_wdata = 32'd0;
      load_start    = 1'b0;
      load_base     = 32'd0;
      load_len      = '0;
      load_val      = 1'b0;
      load_data     = 32'd0;
      err_clr       = 1'b0;
      tick();
      tick();

      // Reset state
      check("rst_busy",     {31'd0, busy},     32'd0);
      check("rst_load_rdy", {31'd0, load_rdy}, 32'd0);
      check("rst_err",      {31'd0, err},      32'd0);
      check("rst_err_code", {30'd0, err_code}, 32'd0);
      check("rst_cnt_if",   cnt_ifetch,        32'd0);
      check("rst_cnt_ld",   cnt_load,          32'd0);
      check("rst_cnt_st",   cnt_store,         32'd0);
      check("rst_iresp",    imemresp_data,     32'd0);
      rst = 1'b0;

      // 1: preload 4 words with gaps, then fetch them back
      start_load(32'h0, 9'd4);
      #1;
      check("t1_busy",     {31'd0, busy},     32'd1);
      check("t1_load_rdy", {31'd0, load_rdy}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         load_val  = 1'b1;
         load_data = 32'hA0A0_0000 | i;
         tick();
         load_val = 1'b0;
         #1;
         if (i < 3) begin
            check("t1_busy_gap", {31'd0, busy}, 32'd1);
            tick();
         end
      end
      check("t1_rdy_drop",  {31'd0, load_rdy}, 32'd0);
      check("t1_busy_drop", {31'd0, busy},     32'd0);
      for (int i = 0; i < 4; i++) begin
         imemreq_val  = 1'b1;
         imemreq_addr = 32'(4 * i);
         #1;
         check("t1_fetch", imemresp_data, 32'hA0A0_0000 | i);
         tick();
      end
      imemreq_val = 1'b0;
      #1;
      check("t1_cnt_if", cnt_ifetch, 32'd4);

      // Known prior content at 0x10 for the read-old check
      start_load(32'h10, 9'd1);
      load_val  = 1'b1;
      load_data = OLD_WORD;
      tick();
      load_val = 1'b0;

      // 2: store + same-cycle fetch of the same word, then load
      dmemreq_val   = 1'b1;
      dmemreq_type  = 1'b1;
      dmemreq_addr  = 32'h10;
      dmemreq_wdata = 32'hDEAD_BEEF;
      imemreq_val   = 1'b1;
      imemreq_addr  = 32'h10;
      #1;
      check("t2_fetch_old", imemresp_data, OLD_WORD);
      tick();
      imemreq_val  = 1'b0;
      dmemreq_type = 1'b0;
      #1;
      check("t2_load_new", dmemresp_rdata, 32'hDEAD_BEEF);
      tick();
      dmemreq_val = 1'b0;
      #1;
      check("t2_cnt_st", cnt_store,  32'd1);
      check("t2_cnt_ld", cnt_load,   32'd1);
      check("t2_cnt_if", cnt_ifetch, 32'd5);

      // 3: misaligned, then out of range, then clear
      dmemreq_val  = 1'b1;
      dmemreq_addr = 32'h12;
      #1;
      check("t3_mis_data", dmemresp_rdata, 32'd0);
      tick();
      dmemreq_addr = 32'h400;
      #1;
      check("t3_err",       {31'd0, err},      32'd1);
      check("t3_code_mis",  {30'd0, err_code}, 32'd1);
      check("t3_rng_data",  dmemresp_rdata,    32'd0);
      tick();
      dmemreq_val = 1'b0;
      #1;
      check("t3_code_keep", {30'd0, err_code}, 32'd1);
      check("t3_cnt_ld",    cnt_load,          32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      #1;
      check("t3_clr_err",  {31'd0, err},      32'd0);
      check("t3_clr_code", {30'd0, err_code}, 32'd0);
      imemreq_val  = 1'b1;
      imemreq_addr = 32'h400;
      tick();
      imemreq_val = 1'b0;
      #1;
      check("t3_code_rng", {30'd0, err_code}, 32'd2);
      err_clr      = 1'b1;
      dmemreq_val  = 1'b1;
      dmemreq_addr = 32'h2;
      tick();
      err_clr     = 1'b0;
      dmemreq_val = 1'b0;
      #1;
      check("t3_clr_vs_new", {30'd0, err_code}, 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;

      // 4: preload wraps from the last word to index 0
      start_load(32'h3FC, 9'd2);
      load_val  = 1'b1;
      load_data = 32'h1111_0001;
      tick();
      load_data = 32'h2222_0002;
      tick();
      load_val = 1'b0;
      #1;
      check("t4_busy", {31'd0, busy}, 32'd0);
      imemreq_val  = 1'b1;
      imemreq_addr = 32'h3FC;
      #1;
      check("t4_last", imemresp_data, 32'h1111_0001);
      tick();
      imemreq_addr = 32'h0;
      #1;
      check("t4_wrap", imemresp_data, 32'h2222_0002);
      tick();
      imemreq_val = 1'b0;
      #1;
      check("t4_cnt_if", cnt_ifetch, 32'd7);

      // 5: core request during LOAD, then reset mid-load
      start_load(32'h20, 9'd3);
      load_val  = 1'b1;
      load_data = 32'hB0B0_0000;
      tick();
      load_val     = 1'b0;
      imemreq_val  = 1'b1;
      imemreq_addr = 32'h0;
      #1;
      check("t5_busy_resp", imemresp_data, 32'd0);
      tick();
      imemreq_val = 1'b0;
      #1;
      check("t5_err",       {31'd0, err},      32'd1);
      check("t5_code_busy", {30'd0, err_code}, 32'd3);
      check("t5_cnt_if",    cnt_ifetch,        32'd7);
      check("t5_still_busy", {31'd0, busy},    32'd1);
      rst = 1'b1;
      #1;
      check("t5_rst_busy", {31'd0, busy},     32'd0);
      check("t5_rst_rdy",  {31'd0, load_rdy}, 32'd0);
      check("t5_rst_err",  {31'd0, err},      32'd0);
      tick();
      rst          = 1'b0;
      imemreq_val  = 1'b1;
      imemreq_addr = 32'h20;
      #1;
      check("t5_persist", imemresp_data, 32'hB0B0_0000);
      tick();
      imemreq_val = 1'b0;

      // 6: load counter saturation
      force dut.cnt_load = 32'hFFFF_FFFE;
      dmemreq_val  = 1'b1;
      dmemreq_type = 1'b0;
      dmemreq_addr = 32'h0;
      tick();
      release dut.cnt_load;
      tick();
      #1;
      check("t6_sat_2", cnt_load, 32'hFFFF_FFFF);
      tick();
      dmemreq_val = 1'b0;
      #1;
      check("t6_sat_3", cnt_load, 32'hFFFF_FFFF);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule : tb_proc_mem_responder
`default_nettype wire
